// File: rtl/serial_logic_unit.sv
// Bit-serial logic unit: applies AND/OR/XOR/NAND to two operands one bit per
// cycle (LSB first), streams each result bit and reports the parallel result.
module serial_logic_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             done_q, done_d;

    // One result bit for the selected operation.
    function automatic logic op_bit(input logic [1:0] sel, input logic a, input logic b);
        logic r;
        case (sel)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

    // Next-state and registered-output logic; ser_out_q always holds bit cnt_q while in RUN.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        out_d       = out_q;
        busy_d      = busy_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d         = A;
                    b_d         = B;
                    op_d        = op;
                    cnt_d       = '0;
                    res_d       = '0;
                    ser_out_d   = op_bit(op, A[0], B[0]);
                    ser_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                res_d[IW'(cnt_q)] = ser_out_q;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    out_d   = res_d;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    a_d         = a_q >> 1;
                    b_d         = b_q >> 1;
                    ser_out_d   = op_bit(op_q, a_d[0], b_d[0]);
                    ser_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            out_q       <= '0;
            busy_q      <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign done      = done_q;
    assign out       = out_q;

endmodule

// File: doc/serial_logic_unit.md
SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: operation select, 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-006 SHALL have port A, input, WIDTH bits: first operand.
REQ-007 SHALL have port B, input, WIDTH bits: second operand.
REQ-008 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-009 SHALL have port ser_out, output, 1 bit: current serial result bit.
REQ-010 SHALL have port ser_valid, output, 1 bit: ser_out qualifier.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port out, output, WIDTH bits: last completed parallel result.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with start=1 at edge N, capture A, B and op into internal registers, clear the bit counter and enter RUN.
REQ-015 SHALL ignore A, B, op and start changes after capture until the FSM returns to IDLE.
REQ-016 SHALL, in RUN, process one operand bit per cycle, LSB first, so that bit k (k = 0..WIDTH-1) appears on ser_out with ser_valid=1 during cycle N+1+k.
REQ-017 SHALL compute each bit as the captured op applied to the bit-k pair: AND a&b; OR a|b; XOR a^b; NAND ~(a&b).
REQ-018 SHALL shift each computed bit into an internal result register at bit position k.
REQ-019 SHALL, after bit WIDTH-1, load out with the full result and enter DONE, so that out is valid in the same cycle that done=1 (cycle N+1+WIDTH).
REQ-020 SHALL assert done for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-021 SHALL hold ser_valid=0 and ser_out=0 in IDLE and DONE.
REQ-022 SHALL ignore start in RUN and DONE: no restart and no queuing; a new request is accepted earliest in the cycle after done.
REQ-023 SHALL hold out unchanged between completions; out changes only on the RUN-to-DONE transition.
REQ-024 SHALL use a bit counter of ceil(log2(WIDTH))+1 bits that never wraps; the terminal count ends RUN.
REQ-025 SHALL give a total latency of WIDTH+1 cycles from the start edge to done (17 cycles for WIDTH=16).

Reset
REQ-026 SHALL, on rst=1, immediately and asynchronously force state=IDLE, counter=0, internal registers=0, out=0, busy=0, done=0, ser_out=0 and ser_valid=0.
REQ-027 SHALL abort any operation in progress on reset, leave out=0 and generate no done pulse for the aborted operation.
REQ-028 SHALL accept start on the first rising edge after rst deasserts.

Verification
REQ-029 AND: A=0xF0F0, B=0xFF00, op=00, start 1 cycle -> ser_out 0 for bits 0..11 and 1 for bits 12..15; done at +17 cycles; out=0xF000.
REQ-030 All ops with the same operands -> OR out=0xFFF0; XOR out=0x0FF0; NAND out=0x0FFF; each run takes 17 cycles.
REQ-031 Start held high continuously with A=0xAAAA, B=0x5555, op=01 -> out=0xFFFF; next capture at the cycle after done; operand changes mid-RUN have no effect.
REQ-032 Reset mid-operation: rst pulse at cycle 8 of RUN -> all outputs 0 immediately, no done; new start with A=0x1234, B=0x00FF, op=00 -> out=0x0034.
REQ-033 Boundaries: A=B=0x0000 with NAND -> out=0xFFFF; A=B=0xFFFF with XOR -> out=0x0000; ser_valid high for exactly 16 cycles per operation.
